spi_param_port: RTL
===================

SPI_PARAM_PORT -- requirements
Module: spi_param_port

Interface
REQ-001 SHALL have parameter PARAM_WIDTH, default 40, meaning data word width in bits (min 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning parameter memory address width (min 1).
REQ-003 SHALL have port clk  input  1  system clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spi_SCLK  input  1  SPI clock, asynchronous to clk.
REQ-006 SHALL have port spi_SSEL  input  1  slave select, active low, asynchronous.
REQ-007 SHALL have port spi_MOSI  input  1  serial data in, asynchronous.
REQ-008 SHALL have port spi_MISO  output  1  serial data out, registered.
REQ-009 SHALL have port rd_addr  output  ADDR_WIDTH  memory read address.
REQ-010 SHALL have port rd_en  output  1  read strobe, one clk pulse.
REQ-011 SHALL have port rd_data  input  PARAM_WIDTH  read data, valid the clk after rd_en.
REQ-012 SHALL have port wr_addr  output  ADDR_WIDTH  memory write address.
REQ-013 SHALL have port wr_data  output  PARAM_WIDTH  memory write data.
REQ-014 SHALL have port wr_en  output  1  write strobe, one clk pulse.
REQ-015 SHALL have port busy  output  1  high while a frame is in progress.
REQ-016 SHALL have port frame_abort  output  1  one clk pulse when a frame ends mid-word.

Function
REQ-017 SHALL pass spi_SCLK, spi_SSEL, spi_MOSI through 2-flop synchronizers on clk before any use.
REQ-018 SHALL support SPI mode 0 only: MOSI sampled on synchronized SCLK rising edge, MISO changed on falling edge, MSB first.
REQ-019 SHALL operate correctly for SCLK high and low phases each >= 4 clk cycles.
REQ-020 SHALL implement states IDLE, HEADER, DATA; IDLE->HEADER on synchronized SSEL falling, HEADER->DATA after ADDR_WIDTH+1 header bits, any state->IDLE on synchronized SSEL high.
REQ-021 SHALL interpret the header as bit 1 = W flag (1 write, 0 read), then start address MSB first, latched into an internal address counter.
REQ-022 SHALL, in DATA, treat each PARAM_WIDTH consecutive bits as one word; frame may carry any number of words.
REQ-023 SHALL, in write mode, on the clk after the rising edge sampling a word's last bit, pulse wr_en with wr_addr = address counter and wr_data = the received word.
REQ-024 SHALL, in read mode, on the clk after the rising edge completing the header or any data word, pulse rd_en with rd_addr = address counter, and load rd_data into the output shift register the following clk.
REQ-025 SHALL drive spi_MISO from shift register MSB; shift left, zero fill, on each SCLK falling edge except the first falling edge after a load.
REQ-026 SHALL increment the address counter after each wr_en or rd_en, wrapping modulo 2^ADDR_WIDTH.
REQ-027 SHALL hold spi_MISO at 0 in IDLE, in HEADER, and throughout write frames.
REQ-028 SHALL, on SSEL deassert with a partial word (1..PARAM_WIDTH-1 bits) or partial header received, discard it, issue no strobe, pulse frame_abort once.
REQ-029 SHALL end a frame on a word boundary without frame_abort; a prefetched read word is discarded silently.
REQ-030 SHALL drive busy = 1 in HEADER and DATA, 0 in IDLE.
REQ-031 SHALL never assert rd_en and wr_en in the same cycle.

Reset
REQ-032 SHALL, when reset is high at a clk edge, enter IDLE and clear rd_en, wr_en, busy, frame_abort, spi_MISO, rd_addr, wr_addr, wr_data, shift registers and bit counter to 0.
REQ-033 SHALL, on reset mid-frame, abandon the frame without strobes or frame_abort and ignore the bus until SSEL next goes high then low.
REQ-034 SHALL give reset priority over all SPI events in the same cycle.

Verification
REQ-035 SHALL pass: write frame W=1, addr 0x10, words 0x12_3456_789A, 0xFF_0000_0001 -> wr_en pulses at 0x10 and 0x11 with those data, no frame_abort.
REQ-036 SHALL pass: read frame W=0, addr 0xFF, memory 0xFF=0xAA_5500_FF11, 0x00=0x01_0203_0405 -> MISO emits both words MSB-first, rd_addr 0xFF then 0x00 (wrap).
REQ-037 SHALL pass: write frame, SSEL deasserted after 17 bits of first word -> no wr_en, one frame_abort pulse, busy falls.
REQ-038 SHALL pass: reset asserted mid-word of a read frame -> all outputs 0 next clk, no strobes until a new frame starts.
REQ-039 SHALL pass: SCLK at minimum 4-clk half-periods, 3-word write -> all 3 words written correctly.
REQ-040 SHALL pass: header-only frame (9 bits, W=1) -> no strobes, no frame_abort.

Source files
------------

// File: rtl/spi_param_port.sv
// SPI mode-0 slave giving word-wide access to a parameter memory.
// Frame: W flag, start address, then any number of PARAM_WIDTH-bit words.
module spi_param_port #(
  parameter int PARAM_WIDTH = 40,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spi_SCLK,
  input  logic                   spi_SSEL,
  input  logic                   spi_MOSI,
  output logic                   spi_MISO,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_en,
  input  logic [PARAM_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PARAM_WIDTH-1:0] wr_data,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   frame_abort
);

  localparam int HDR_BITS = ADDR_WIDTH + 1;
  localparam int RW =
    (PARAM_WIDTH > HDR_BITS) ? PARAM_WIDTH : HDR_BITS;
  localparam int CW = $clog2(RW + 1);
  localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BITS - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(PARAM_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  state_t                 state;
  logic [1:0]             sclk_q;
  logic [1:0]             ssel_q;
  logic [1:0]             mosi_q;
  logic                   sclk_d;
  logic                   ssel_d;
  logic [CW-1:0]          bit_cnt;
  logic [RW-2:0]          rx_sr;
  logic [PARAM_WIDTH-1:0] tx_sr;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   wr_mode;
  logic                   load_pend;
  logic                   skip_shift;

  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   ssel_fall;
  logic                   ssel_s;
  logic [RW-1:0]          rx_word;
  logic [ADDR_WIDTH-1:0]  hdr_addr;
  logic                   hdr_w;

  // Edge detection and the word being completed by the current bit
  always_comb begin
    ssel_s    = ssel_q[1];
    sclk_rise = sclk_q[1] & ~sclk_d;
    sclk_fall = ~sclk_q[1] & sclk_d;
    ssel_fall = ~ssel_q[1] & ssel_d;
    rx_word   = {rx_sr, mosi_q[1]};
    hdr_addr  = rx_word[ADDR_WIDTH-1:0];
    hdr_w     = rx_word[ADDR_WIDTH];
  end

  // Synchronizers, frame FSM, shift registers and memory strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sclk_q      <= '0;
      ssel_q      <= '0;
      mosi_q      <= '0;
      sclk_d      <= 1'b0;
      ssel_d      <= 1'b0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      addr        <= '0;
      wr_mode     <= 1'b0;
      load_pend   <= 1'b0;
      skip_shift  <= 1'b0;
      spi_MISO    <= 1'b0;
      rd_addr     <= '0;
      rd_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[0], spi_SCLK};
      ssel_q      <= {ssel_q[0], spi_SSEL};
      mosi_q      <= {mosi_q[0], spi_MOSI};
      sclk_d      <= sclk_q[1];
      ssel_d      <= ssel_q[1];
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      frame_abort <= 1'b0;
      load_pend   <= rd_en;
      if (state != IDLE && ssel_s) begin
        // a frame cut mid-header or mid-word is dropped
        state       <= IDLE;
        busy        <= 1'b0;
        frame_abort <= (bit_cnt != '0);
        bit_cnt     <= '0;
        spi_MISO    <= 1'b0;
        skip_shift  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            spi_MISO <= 1'b0;
            if (ssel_fall) begin
              state   <= HEADER;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          HEADER: begin
            spi_MISO <= 1'b0;
            if (sclk_rise) begin
              rx_sr <= rx_word[RW-2:0];
              if (bit_cnt == HDR_LAST) begin
                bit_cnt <= '0;
                state   <= DATA;
                wr_mode <= hdr_w;
                if (!hdr_w) begin
                  rd_en   <= 1'b1;
                  rd_addr <= hdr_addr;
                  addr    <= hdr_addr + 1'b1;
                end else begin
                  addr    <= hdr_addr;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_sr <= rx_word[RW-2:0];
              if (bit_cnt == WORD_LAST) begin
                bit_cnt <= '0;
                addr    <= addr + 1'b1;
                if (wr_mode) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= rx_word[PARAM_WIDTH-1:0];
                end else begin
                  rd_en   <= 1'b1;
                  rd_addr <= addr;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (wr_mode) begin
              spi_MISO <= 1'b0;
            end else if (load_pend) begin
              tx_sr      <= rd_data;
              skip_shift <= 1'b1;
            end else if (sclk_fall) begin
              if (skip_shift) begin
                spi_MISO   <= tx_sr[PARAM_WIDTH-1];
                skip_shift <= 1'b0;
              end else begin
                spi_MISO <= tx_sr[PARAM_WIDTH-2];
                tx_sr    <= {tx_sr[PARAM_WIDTH-2:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
